ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifq_pkg.sv | 16 +
 rtl/ifq_fifo.sv | 52 +++++
 rtl/ifetch_queue.sv | 125 ++++++++++++
 tb/tb_ifetch_queue.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package ifq_pkg;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned INSTR_W = 32;

   localparam int unsigned           IFQ_DEPTH    = 4;
   localparam logic [ADDR_W-1:0]     IFQ_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HALT  = 2'd1,
      ERR   = 2'd2
   } ifq_state_e;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO holding fetched {pc, word} entries; flush has priority over push/pop.
module ifq_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic                    rvalid,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (cnt != '0);
   assign do_push = push && ((cnt != FULL_CNT) || do_pop);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // NOTE: storage is deliberately not reset; validity lives in cnt, so stale slots are never observed.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

   assign rdata  = mem[rd_ptr];
   assign rvalid = (cnt != '0);
   assign count  = cnt;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: credit-limited fetch issue, in-order response tracking,
// redirect/discard handling and a sticky misaligned-redirect error state.
module ifetch_queue
   import ifq_pkg::*;
#(
   parameter int unsigned        DEPTH    = IFQ_DEPTH,
   parameter logic [ADDR_W-1:0]  RESET_PC = IFQ_RESET_PC
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clk_en,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic                imem_rvalid,
   input  logic [INSTR_W-1:0]  imem_rdata,
   input  logic                redirect_v,
   input  logic [ADDR_W-1:0]   redirect_pc,
   input  logic                halt_f,
   output logic                instr_v,
   output logic [INSTR_W-1:0]  instr,
   output logic [ADDR_W-1:0]   instr_pc,
   input  logic                instr_rdy,
   output logic                fetch_err
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned PW = ADDR_W - 2;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   ifq_state_e state;
   ifq_state_e state_nxt;

   // PCs are kept as word addresses, which keeps requests aligned by construction.
   logic [PW-1:0]  fetch_wpc;
   logic [PW-1:0]  rsp_wpc;
   logic [CW-1:0]  outstanding;
   logic [CW-1:0]  discard_cnt;
   logic [CW-1:0]  occupancy;
   logic [CW:0]    credit_used;
   logic           rsp_v;
   logic           redirect_bad;
   logic           flush;
   logic           push;
   logic           pop;
   logic           head_v;
   logic [ADDR_W+INSTR_W-1:0] head;

   // A response with nothing outstanding can only belong to a pre-reset request.
   assign rsp_v        = imem_rvalid && (outstanding != '0);
   assign redirect_bad = redirect_v && (redirect_pc[1:0] != 2'b00);
   assign credit_used  = {1'b0, occupancy} + {1'b0, outstanding};

   always_ff @(posedge clk) begin
      if (rst)         state <= FETCH;
      else if (clk_en) state <= state_nxt;
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_nxt = state;
      imem_req  = 1'b0;
      flush     = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      if (clk_en && !rst) begin
         unique case (state)
            FETCH: begin
               if (redirect_bad) state_nxt = ERR;
               else if (halt_f)  state_nxt = HALT;
               imem_req = !halt_f && !redirect_v && (credit_used < DEPTH_W);
            end
            HALT: begin
               if (redirect_bad)    state_nxt = ERR;
               else if (redirect_v) state_nxt = FETCH;
            end
            default: state_nxt = ERR;
         endcase
         flush = redirect_v || (state == ERR);
         push  = rsp_v && (discard_cnt == '0) && !flush;
         pop   = head_v && instr_rdy && !flush;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_wpc   <= RESET_PC[ADDR_W-1:2];
         rsp_wpc     <= RESET_PC[ADDR_W-1:2];
         outstanding <= '0;
         discard_cnt <= '0;
      end else if (clk_en) begin
         outstanding <= outstanding + CW'(imem_req) - CW'(rsp_v);
         if (redirect_v && (state != ERR)) begin
            // Everything still in flight belongs to the old path, except a response landing now.
            fetch_wpc   <= redirect_pc[ADDR_W-1:2];
            rsp_wpc     <= redirect_pc[ADDR_W-1:2];
            discard_cnt <= outstanding - CW'(rsp_v);
         end else begin
            if (imem_req) fetch_wpc <= fetch_wpc + PW'(1);
            if (push)     rsp_wpc   <= rsp_wpc + PW'(1);
            if (rsp_v && (discard_cnt != '0)) discard_cnt <= discard_cnt - CW'(1);
         end
      end
   end

   ifq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ADDR_W + INSTR_W)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (push),
      .pop    (pop),
      .flush  (flush),
      .wdata  ({rsp_wpc, 2'b00, imem_rdata}),
      .rdata  (head),
      .rvalid (head_v),
      .count  (occupancy)
   );

   assign imem_addr         = {fetch_wpc, 2'b00};
   assign instr_v           = head_v;
   assign {instr_pc, instr} = head_v ? head : '0;
   assign fetch_err         = (state == ERR);

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus a randomized run,
// all checked against a transaction-level model with a latency-programmable memory.
module tb_ifetch_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_v;
   logic [31:0] redirect_pc;
   logic        halt_f;
   logic        instr_v;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_rdy;
   logic        fetch_err;

   ifetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clk_en      (clk_en),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect_v  (redirect_v),
      .redirect_pc (redirect_pc),
      .halt_f      (halt_f),
      .instr_v     (instr_v),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_rdy   (instr_rdy),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; }        mem_rsp_t;
   typedef struct { logic [31:0] pc;   bit stale; }      flight_t;
   typedef struct { logic [31:0] pc;   logic [31:0] word; } entry_t;

   mem_rsp_t    mem_q[$];
   flight_t     fl_q[$];
   entry_t      exp_q[$];
   logic [31:0] m_pc;
   bit          m_halted;
   bit          m_err;

   int          cyc;
   int          lat_lo;
   int          lat_hi;
   int          tests_run;
   int          tests_failed;
   int          n_req;
   int          n_pop;
   logic [31:0] last_addr;
   bit          obs_v;
   logic [31:0] obs_pc;
   logic [31:0] obs_word;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h0001_0003) ^ 32'hC0DE_F00D;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b1;
      clk_en      = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      redirect_v  = 1'b0;
      redirect_pc = '0;
      halt_f      = 1'b0;
      instr_rdy   = 1'b0;
      repeat (2) @(posedge clk);
      mem_q.delete();
      fl_q.delete();
      exp_q.delete();
      m_pc     = 32'h0;
      m_halted = 1'b0;
      m_err    = 1'b0;
   endtask

   // One clock cycle: drive inputs and memory response, compare outputs with the model, advance the model.
   task automatic step(input bit en, input bit rdy, input bit halt, input bit rdv, input logic [31:0] rpc);
      bit      rv;
      bit      e_req;
      bit      e_v;
      bit      keep;
      flight_t f;
      @(negedge clk);
      rst         = 1'b0;
      clk_en      = en;
      instr_rdy   = rdy;
      halt_f      = halt;
      redirect_v  = rdv;
      redirect_pc = rpc;
      rv          = 1'b0;
      imem_rdata  = '0;
      // The memory is clock-gated together with the queue.
      if (en && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         rv         = 1'b1;
         imem_rdata = mem_word(mem_q[0].addr);
         void'(mem_q.pop_front());
      end
      imem_rvalid = rv;
      #1;
      e_req = en && !m_err && !m_halted && !halt && !rdv && (exp_q.size() + fl_q.size() < DEPTH);
      e_v   = (exp_q.size() > 0);
      tests_run++;
      if (imem_req !== e_req) begin
         tests_failed++;
         $display("FAIL imem_req cyc %0d: got %b expected %b", cyc, imem_req, e_req);
      end
      if (e_req) begin
         tests_run++;
         if (imem_addr !== m_pc) begin
            tests_failed++;
            $display("FAIL imem_addr cyc %0d: got %h expected %h", cyc, imem_addr, m_pc);
         end
      end
      tests_run++;
      if (instr_v !== e_v) begin
         tests_failed++;
         $display("FAIL instr_v cyc %0d: got %b expected %b", cyc, instr_v, e_v);
      end
      if (e_v) begin
         tests_run++;
         if (instr_pc !== exp_q[0].pc || instr !== exp_q[0].word) begin
            tests_failed++;
            $display("FAIL head cyc %0d: got pc %h word %h expected pc %h word %h",
                     cyc, instr_pc, instr, exp_q[0].pc, exp_q[0].word);
         end
      end
      tests_run++;
      if (fetch_err !== m_err) begin
         tests_failed++;
         $display("FAIL fetch_err cyc %0d: got %b expected %b", cyc, fetch_err, m_err);
      end
      obs_v    = (instr_v === 1'b1);
      obs_pc   = instr_pc;
      obs_word = instr;
      if (imem_req === 1'b1) begin
         mem_q.push_back('{imem_addr, cyc + int'($urandom_range(lat_hi, lat_lo))});
         n_req++;
         last_addr = imem_addr;
      end
      if (en && instr_v === 1'b1 && rdy && !rdv) n_pop++;
      if (en) begin
         keep = 1'b0;
         if (rv && fl_q.size() > 0) begin
            f    = fl_q.pop_front();
            keep = !f.stale;
         end
         if (m_err || (rdv && rpc[1:0] != 2'b00)) begin
            m_err = 1'b1;
            exp_q.delete();
         end else if (rdv) begin
            exp_q.delete();
            foreach (fl_q[i]) fl_q[i].stale = 1'b1;
            m_pc     = rpc;
            m_halted = !m_halted && halt;
         end else begin
            if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
            if (keep) exp_q.push_back('{f.pc, mem_word(f.pc)});
            if (e_req) begin
               fl_q.push_back('{m_pc, 1'b0});
               m_pc = m_pc + 32'd4;
            end
            if (halt) m_halted = 1'b1;
         end
      end
      cyc++;
   endtask

   task automatic test_reset();
      do_reset();
      lat_lo = 1; lat_hi = 1;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      do_reset();
      #1;
      tests_run++;
      if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset imem_req: got %b expected 0", imem_req); end
      tests_run++;
      if (instr_v !== 1'b0) begin tests_failed++; $display("FAIL reset instr_v: got %b expected 0", instr_v); end
      tests_run++;
      if (instr !== 32'h0) begin tests_failed++; $display("FAIL reset instr: got %h expected 0", instr); end
      tests_run++;
      if (instr_pc !== 32'h0) begin tests_failed++; $display("FAIL reset instr_pc: got %h expected 0", instr_pc); end
      tests_run++;
      if (fetch_err !== 1'b0) begin tests_failed++; $display("FAIL reset fetch_err: got %b expected 0", fetch_err); end
   endtask

   task automatic test_stream();
      do_reset();
      lat_lo = 1; lat_hi = 1; n_req = 0; n_pop = 0;
      for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      tests_run++;
      if (n_req != 24) begin tests_failed++; $display("FAIL stream requests: got %0d expected 24", n_req); end
      tests_run++;
      if (n_pop != 22) begin tests_failed++; $display("FAIL stream pops: got %0d expected 22", n_pop); end
      tests_run++;
      if (last_addr !== 32'd92) begin tests_failed++; $display("FAIL stream last addr: got %h expected 0000005c", last_addr); end
   endtask

   task automatic test_backpressure();
      do_reset();
      lat_lo = 1; lat_hi = 1; n_req = 0;
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      tests_run++;
      if (n_req != 4) begin tests_failed++; $display("FAIL backpressure requests: got %0d expected 4", n_req); end
      tests_run++;
      if (!obs_v || obs_pc !== 32'h0) begin tests_failed++; $display("FAIL backpressure head: got v %b pc %h expected v 1 pc 0", obs_v, obs_pc); end
      n_req = 0;
      step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      tests_run++;
      if (n_req != 1) begin tests_failed++; $display("FAIL backpressure refill count: got %0d expected 1", n_req); end
      tests_run++;
      if (last_addr !== 32'h10) begin tests_failed++; $display("FAIL backpressure refill addr: got %h expected 00000010", last_addr); end
   endtask

   task automatic test_redirect();
      bit found;
      do_reset();
      lat_lo = 3; lat_hi = 3;
      step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, '0);
         found = obs_v;
      end
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("FAIL redirect first instr: got none within 20 cycles expected pc 00000100");
      end else if (obs_pc !== 32'h100 || obs_word !== mem_word(32'h100)) begin
         tests_failed++;
         $display("FAIL redirect first instr: got pc %h word %h expected pc 00000100 word %h", obs_pc, obs_word, mem_word(32'h100));
      end
   endtask

   task automatic test_halt();
      do_reset();
      lat_lo = 3; lat_hi = 3;
      step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      n_req = 0; n_pop = 0;
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
      tests_run++;
      if (n_req != 0) begin tests_failed++; $display("FAIL halt requests: got %0d expected 0", n_req); end
      tests_run++;
      if (n_pop != 2) begin tests_failed++; $display("FAIL halt drained: got %0d expected 2", n_pop); end
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
      step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      tests_run++;
      if (n_req != 1 || last_addr !== 32'h40) begin
         tests_failed++;
         $display("FAIL halt resume: got %0d reqs last %h expected 1 reqs last 00000040", n_req, last_addr);
      end
   endtask

   task automatic test_misaligned();
      do_reset();
      lat_lo = 2; lat_hi = 2;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h102);
      n_req = 0;
      step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      tests_run++;
      if (fetch_err !== 1'b1 || instr_v !== 1'b0) begin
         tests_failed++;
         $display("FAIL misaligned entry: got err %b v %b expected err 1 v 0", fetch_err, instr_v);
      end
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'($urandom_range(1, 0)), 32'h200);
      tests_run++;
      if (n_req != 0 || fetch_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL misaligned sticky: got %0d reqs err %b expected 0 reqs err 1", n_req, fetch_err);
      end
   endtask

   task automatic test_clk_en();
      logic [31:0] addr_before;
      do_reset();
      lat_lo = 2; lat_hi = 2;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      addr_before = last_addr;
      n_req = 0;
      for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(1, 0)), 1'b1, 1'b0, '0);
      tests_run++;
      if (n_req != 0) begin tests_failed++; $display("FAIL clk_en hold requests: got %0d expected 0", n_req); end
      step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      tests_run++;
      if (n_req != 1 || last_addr !== addr_before + 32'd4) begin
         tests_failed++;
         $display("FAIL clk_en resume: got %0d reqs last %h expected 1 reqs last %h", n_req, last_addr, addr_before + 32'd4);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      lat_lo = 1; lat_hi = 1;
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
      n_req = 0;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      tests_run++;
      if (n_req != 4 || last_addr !== 32'h4) begin
         tests_failed++;
         $display("FAIL wrap: got %0d reqs last %h expected 4 reqs last 00000004", n_req, last_addr);
      end
   endtask

   task automatic test_random();
      bit          en;
      bit          rdy;
      bit          halt;
      bit          rdv;
      logic [31:0] rpc;
      do_reset();
      lat_lo = 1; lat_hi = 4; n_pop = 0;
      for (int i = 0; i < 3000; i++) begin
         en   = ($urandom_range(7, 0) != 0);
         rdy  = ($urandom_range(3, 0) != 0);
         halt = ($urandom_range(31, 0) == 0);
         rdv  = ($urandom_range(15, 0) == 0);
         rpc  = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'h0000_FFFC);
         step(en, rdy, halt, rdv, rpc);
      end
      tests_run++;
      if (n_pop == 0) begin tests_failed++; $display("FAIL random progress: got 0 instrs expected some"); end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      cyc          = 0;
      lat_lo       = 1;
      lat_hi       = 1;
      n_req        = 0;
      n_pop        = 0;
      last_addr    = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_misaligned();
      test_clk_en();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
